serial_subtractor: RTL

//   Bit-serial N-bit subtractor; the sequential inverse companion to the half-adder datapath.

---
 rtl/serial_sub_pkg.sv | 20 ++
 rtl/serial_subtractor_full_subtractor.sv | 34 +++
 rtl/serial_subtractor.sv | 136 +++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared constants and helpers for the bit-serial subtractor.
// State encoding and counter sizing live here.
package serial_sub_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // Bits needed to count 0..v-1, never less than one.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor built only from two-input NAND gates.
// d = x ^ y ^ bin ; bout = (~x & y) | (~(x ^ y) & bin)
module full_subtractor (
  output logic d,
  output logic bout,
  input  logic x,
  input  logic y,
  input  logic bin
);

  logic n1, n2, n3, p;
  logic m1, m2, m3;
  logic nx, np, t1, t2;

  // p = x ^ y
  nand g_n1 (n1, x, y);
  nand g_n2 (n2, x, n1);
  nand g_n3 (n3, y, n1);
  nand g_p  (p, n2, n3);

  // d = p ^ bin
  nand g_m1 (m1, p, bin);
  nand g_m2 (m2, p, m1);
  nand g_m3 (m3, bin, m1);
  nand g_d  (d, m2, m3);

  // bout = (~x & y) | (~p & bin)
  nand g_nx (nx, x, x);
  nand g_np (np, p, p);
  nand g_t1 (t1, nx, y);
  nand g_t2 (t2, np, bin);
  nand g_bo (bout, t1, t2);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CW-1:0]    cnt;
  logic             bit_d;
  logic             bit_bout;
  logic             last_bit;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  assign last_bit = (cnt == LAST);

  // The single shared bit cell: current LSBs plus the running borrow.
  full_subtractor u_cell (
    .d    (bit_d),
    .bout (bit_bout),
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (borrow_out)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; DONE always lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN:  if (last_bit) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_RUN:  busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath: capture on accepted start, shift one bit per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sh       <= a;
            b_sh       <= b;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
          end
        end
        S_RUN: begin
          a_sh       <= a_sh >> 1;
          b_sh       <= b_sh >> 1;
          diff       <= {bit_d, diff[WIDTH-1:1]};
          borrow_out <= bit_bout;
          cnt        <= cnt + CW'(1);
        end
        default: begin
          a_sh <= a_sh;
        end
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Signed overflow: operand signs differ and result sign differs from a.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf   <= 1'b0;
    end else if (state == S_IDLE && start) begin
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
      ovf   <= 1'b0;
    end else if (state == S_RUN && last_bit) begin
      ovf <= (a_msb != b_msb) && (bit_d != a_msb);
    end
  end
`endif

endmodule
